uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int OVERSAMPLE = 16;  // s_tick pulses per bit time
  localparam int MID_TICK   = 7;   // s count at the middle of the start bit

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta, r_sync;

  // Resolve metastability over two flops; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: 1 start bit, DBIT data bits LSB first,
// SB_TICK ticks of stop. Flags framing errors and drops start-bit glitches.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  uart_state_e     r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic            w_rx_s;
  logic            r_rx_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // State, counters, shift register, outputs and the edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_rx_d  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
      r_rx_d  <= w_rx_s;
    end
  end

  // Next-state and datapath: everything advances on s_tick, except the
  // idle->start transition, which fires on the synchronised falling edge.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = r_ferr;
    case (r_state)
      IDLE: begin
        // Edge detect rather than level, so a held-low break cannot re-arm.
        if (r_rx_d && !w_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            w_s_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;  // glitch: silently drop
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) w_state_nxt = STOP;
            else               w_n_nxt     = r_n + NW'(1);
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            // With SB_TICK=16 this lands mid stop bit, leaving half a bit of
            // slack to catch the next start edge.
            w_state_nxt = IDLE;
            w_s_nxt     = '0;
            w_done_nxt  = 1'b1;
            w_dout_nxt  = r_b;
            w_ferr_nxt  = ~w_rx_s;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are driven and
// checked when rx_done_tick fires.
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_pulse = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_fe = 1'b0;
  logic       prev_done = 1'b0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // s_tick: one clk high out of every four.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      s_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; stop_lvl is the stop-bit line level.
  task automatic send(input logic [7:0] d, input logic stop_lvl);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_lvl;
    q.push_back(e);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
    rx = stop_lvl;
    wait_clk(BIT_CLK);
  endtask

  // Monitor: every pulse must match the oldest queued frame and be 1 clk wide.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      n_pulse++;
      chk("pulse_width", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        chk("spurious_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e.d});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        last_dout = e.d;
        last_fe   = e.fe;
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    int p0;
    rx    = 1'b1;
    reset = 1'b1;
    wait_clk(4);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
    reset = 1'b0;
    wait_clk(BIT_CLK);

    // Single frame.
    p0 = n_pulse;
    send(8'hA5, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("a5_pending", q.size(), 32'd0);
    chk("a5_pulses", n_pulse - p0, 32'd1);

    // Back-to-back, no idle gap.
    p0 = n_pulse;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("b2b_pending", q.size(), 32'd0);
    chk("b2b_pulses", n_pulse - p0, 32'd2);

    // Start-bit glitch: 4 ticks low.
    p0 = n_pulse;
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(3 * BIT_CLK);
    chk("glitch_pulses", n_pulse - p0, 32'd0);
    chk("glitch_dout", {24'd0, dout}, 32'hFF);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);

    // Framing error, then a good frame clears the flag.
    send(8'h3C, 1'b0);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    send(8'h55, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("fe_pending", q.size(), 32'd0);
    chk("fe_clear", {31'd0, frame_err}, 32'd0);

    // Break: 30 bit-times low gives exactly one errored all-zero frame.
    p0 = n_pulse;
    begin
      exp_t e;
      e.d  = 8'h00;
      e.fe = 1'b1;
      q.push_back(e);
    end
    rx = 1'b0;
    wait_clk(30 * BIT_CLK);
    chk("brk_pulses", n_pulse - p0, 32'd1);
    chk("brk_pending", q.size(), 32'd0);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("brk_rearm", n_pulse - p0, 32'd1);
    send(8'h12, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("brk_next_pending", q.size(), 32'd0);

    // Reset during bit 3 of 0xC3.
    p0 = n_pulse;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rx = (8'hC3 >> i) & 1;
      wait_clk(BIT_CLK);
    end
    rx = 1'b0;  // bit 3 of 0xC3
    wait_clk(BIT_CLK / 2);
    reset = 1'b1;
    wait_clk(2);
    rx = 1'b1;
    reset = 1'b0;
    wait_clk(12 * BIT_CLK);
    chk("rst_mid_pulses", n_pulse - p0, 32'd0);
    chk("rst_mid_dout", {24'd0, dout}, 32'd0);
    chk("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
    send(8'h81, 1'b1);
    wait_clk(2 * BIT_CLK);
    chk("post_rst_pending", q.size(), 32'd0);
    chk("post_rst_dout", {24'd0, dout}, 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
